ifu_pc_fetch: RTL and testbench

- Instruction-fetch stage that owns the architectural PC register.
- Issues fetches to instruction memory and presents each fetched instruction, with its PC, to decode over a valid/ready handshake.
- Loads the PC from the next-PC computation when the current instruction commits.
- Detects misaligned PCs and memory access errors, and holds a fault until reset.

---
 rtl/ifu_pc_fetch.sv | 139 +++++++++++++
 tb/tb_ifu_pc_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_pc_fetch.sv
// rtl/ifu_pc_fetch.sv - instruction fetch stage owning the architectural PC
module ifu_pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      next_pc,
   input  logic             next_pc_valid,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [31:0]      imem_addr,
   input  logic             imem_rsp_valid,
   output logic             imem_rsp_ready,
   input  logic [31:0]      imem_rsp_data,
   input  logic             imem_rsp_err,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [31:0]      pc,
   output logic             fetch_fault,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RSP   = 3'd2,
      S_OUT   = 3'd3,
      S_WAIT  = 3'd4,
      S_FAULT = 3'd5
   } state_e;

   localparam logic [1:0] CAUSE_NONE      = 2'b00;
   localparam logic [1:0] CAUSE_ACCESS    = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGN  = 2'b10;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             commit;

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 32'h0000_0000;
         cause_q <= CAUSE_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: fetch sequencing, commit of next_pc and fault capture.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  cause_d = CAUSE_ACCESS;
                  state_d = S_FAULT;
               end else begin
                  inst_d  = imem_rsp_data;
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (inst_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               // A single-cycle execute may commit in the handoff cycle itself.
               if (next_pc_valid) begin
                  commit = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (next_pc_valid) begin
               commit = 1'b1;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The PC takes the committed value even when it faults, so the faulting
      // address stays visible.
      if (commit) begin
         pc_d = next_pc;
         if (next_pc[1:0] != 2'b00) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_FAULT;
         end else begin
            state_d = S_REQ;
         end
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_rsp_ready = (state_q == S_RSP);
   assign inst_valid     = (state_q == S_OUT);
   assign fetch_fault    = (state_q == S_FAULT);
   assign imem_addr      = pc_q;
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign fault_cause    = cause_q;
   assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// tb/tb_ifu_pc_fetch.sv - randomized scoreboard bench for ifu_pc_fetch
module tb_ifu_pc_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          CW     = 4;
   localparam int          NCYC   = 4000;
   localparam int          FAST   = 60;

   logic          clk;
   logic          rst;
   logic [31:0]   next_pc;
   logic          next_pc_valid;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [31:0]   imem_addr;
   logic          imem_rsp_valid;
   logic          imem_rsp_ready;
   logic [31:0]   imem_rsp_data;
   logic          imem_rsp_err;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   inst;
   logic [31:0]   pc;
   logic          fetch_fault;
   logic [1:0]    fault_cause;
   logic [CW-1:0] fetch_cnt;

   ifu_pc_fetch #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .next_pc(next_pc), .next_pc_valid(next_pc_valid),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .pc(pc), .fetch_fault(fetch_fault), .fault_cause(fault_cause),
      .fetch_cnt(fetch_cnt)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: transaction-level view of what the fetch stage owes.
   logic [31:0] m_pc;
   int          m_cnt;
   bit          exp_req, pending, exp_out, armed, exp_fault;
   logic [1:0]  exp_cause;
   int          rsp_wait;
   int          fault_cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = RST_PC;
      m_cnt     = 0;
      exp_req   = 1'b0;
      pending   = 1'b0;
      exp_out   = 1'b0;
      armed     = 1'b0;
      exp_fault = 1'b0;
      exp_cause = 2'b00;
      rsp_wait  = 0;
      fault_cyc = 0;
      sb.delete();
   endtask

   // Stimulus driver and model update; checks architectural state each cycle.
   initial begin
      int          hold;
      int          stall;
      int          r;
      bit          fast, releasing, first_done, do_rst;
      bit          reqhs, rsphs, insths, commit;
      logic [31:0] rnd;

      rst = 1'b1;
      next_pc = '0; next_pc_valid = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
      model_reset();
      first_done = 1'b0;
      stall = 0;
      #1 rst = 1'b0;
      hold = 2;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         chk("pc", pc, m_pc);
         chk("imem_addr", imem_addr, m_pc);
         chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
         chk("imem_rsp_ready", 32'(imem_rsp_ready), 32'(pending));
         chk("inst_valid", 32'(inst_valid), 32'(exp_out));
         chk("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
         chk("fault_cause", 32'(fault_cause), 32'(exp_cause));
         chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
         if (exp_fault) fault_cyc++;

         fast = (cyc < FAST);
         releasing = 1'b0;
         do_rst = 1'b0;
         if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               rst = 1'b1;
               releasing = 1'b1;
            end
         end else if (!fast) begin
            if (exp_fault && fault_cyc >= 20) do_rst = 1'b1;
            else if (pending && $urandom_range(0, 79) == 0) do_rst = 1'b1;
            else if ($urandom_range(0, 999) == 0) do_rst = 1'b1;
         end
         if (do_rst) begin
            rst = 1'b0;
            model_reset();
            hold = 2;
         end

         imem_req_ready = fast ? 1'b1 : ($urandom_range(0, 99) < 60);
         if (pending && rsp_wait > 0) begin
            rsp_wait--;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(0, 1));
         end else if (pending) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = (fast && !first_done) ? 32'h0000_0413 : $urandom;
            imem_rsp_err   = fast ? 1'b0 : ($urandom_range(0, 59) == 0);
            first_done     = 1'b1;
         end else begin
            imem_rsp_valid = !fast && ($urandom_range(0, 3) == 0);
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(0, 1));
         end
         inst_ready = fast ? 1'b1 : ($urandom_range(0, 99) < 45);
         if (armed || (exp_out && inst_ready)) begin
            next_pc_valid = fast ? 1'b1 : ($urandom_range(0, 99) < 50);
            r   = int'($urandom_range(0, 99));
            rnd = $urandom;
            if (fast || r >= 10) next_pc = m_pc + 32'd4;
            else if (r < 2) next_pc = m_pc + 32'd2;
            else next_pc = {rnd[31:2], 2'b00};
         end else begin
            next_pc_valid = !fast && ($urandom_range(0, 4) == 0);
            next_pc = $urandom;
         end

         reqhs = 1'b0; rsphs = 1'b0; insths = 1'b0; commit = 1'b0;
         if (rst) begin
            reqhs  = exp_req && imem_req_ready;
            rsphs  = pending && imem_rsp_valid;
            insths = exp_out && inst_ready;
            commit = (armed || insths) && next_pc_valid;
            if (reqhs) begin
               exp_req  = 1'b0;
               pending  = 1'b1;
               rsp_wait = fast ? 0 : int'($urandom_range(0, 3));
            end
            if (rsphs) begin
               pending = 1'b0;
               if (imem_rsp_err) begin
                  exp_fault = 1'b1;
                  exp_cause = 2'b01;
               end else begin
                  sb.push_back('{pc: m_pc, inst: imem_rsp_data});
                  exp_out = 1'b1;
               end
            end
            if (insths) begin
               exp_out = 1'b0;
               m_cnt   = (m_cnt + 1) % (1 << CW);
               armed   = 1'b1;
            end
            if (commit) begin
               armed = 1'b0;
               m_pc  = next_pc;
               if (next_pc[1:0] != 2'b00) begin
                  exp_fault = 1'b1;
                  exp_cause = 2'b10;
               end else begin
                  exp_req = 1'b1;
               end
            end
         end
         if (releasing) exp_req = 1'b1;

         if (reqhs || rsphs || insths || commit || exp_fault || !rst || releasing || pending || armed)
            stall = 0;
         else
            stall++;
         if (stall > 60) begin
            checks++;
            errors++;
            $display("FAIL liveness: no progress for %0d cycles, expected progress within 60", stall);
            stall = 0;
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Scoreboard monitor: compares the presented instruction against the queue.
   always @(negedge clk) begin
      #1;
      if (rst && inst_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL inst_unexpected: inst_valid with %h at pc %h, expected no instruction", inst, pc);
         end else begin
            chk("inst", inst, sb[0].inst);
            chk("inst_pc", pc, sb[0].pc);
            if (inst_ready) void'(sb.pop_front());
         end
      end
   end

endmodule
